result_serializer: RTL and testbench
====================================

RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the result width in bits; legal values are multiples of 8 from 8 to 64.
REQ-002 The block SHALL have parameter BCD_DIGITS, default 8, giving the number of display digits; legal values are 1 to 16.
REQ-003 The block SHALL have parameter MSB_FIRST, default 0: 0 sends byte 0 (LSB) first, 1 sends byte NB-1 first, where NB = DATA_W/8.
REQ-004 The block SHALL have port clk, input, 1 bit: clock, rising-edge active.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port capture, input, 1 bit: latch result_data.
REQ-007 The block SHALL have port result_data, input, DATA_W bits: result value, unsigned.
REQ-008 The block SHALL have port disp_mode, input, 1 bit: the current result is displayable.
REQ-009 The block SHALL have port start, input, 1 bit: request serial transmission of the held result.
REQ-010 The block SHALL have port tx_ready, input, 1 bit: the UART transmitter accepts a byte.
REQ-011 The block SHALL have port tx_valid, output, 1 bit: tx_data is valid.
REQ-012 The block SHALL have port tx_data, output, 8 bits: byte being offered.
REQ-013 The block SHALL have port busy, output, 1 bit: transmission in progress.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last byte is accepted.
REQ-015 The block SHALL have port bcd_out, output, 4*BCD_DIGITS bits: saturated held result in packed BCD, least significant digit in bits [3:0].
REQ-016 The block SHALL have port bcd_valid, output, 1 bit: bcd_out reflects the currently held result.
REQ-017 The block SHALL have port en_disp, output, 1 bit: display enable registered with the held result.

Function
REQ-018 The block SHALL contain a DATA_W-bit hold register and an en_disp register.
- On a clk edge with capture=1 and busy=0, the hold register SHALL load result_data and en_disp SHALL load disp_mode.
- Otherwise both registers SHALL keep their values.
REQ-019 The block SHALL ignore capture while busy=1; the hold register, en_disp and the conversion SHALL all be unaffected.
REQ-020 The transmit FSM SHALL have the states IDLE, SEND and DONE.
- IDLE -> SEND on start=1 with capture=0.
- SEND -> DONE when the last byte is accepted.
- DONE -> IDLE unconditionally after 1 cycle.
REQ-021 If start and capture are both high in IDLE, capture SHALL take effect and start SHALL be dropped.
REQ-022 busy SHALL be 1 in SEND and DONE and 0 in IDLE; done SHALL be 1 only in DONE.
REQ-023 In SEND, tx_valid SHALL be 1, and tx_data SHALL be byte[idx] of the hold register, with byte[i] = bits [8i+7:8i].
- idx starts at 0 (MSB_FIRST=0) or NB-1 (MSB_FIRST=1).
- idx steps by +1 or -1 respectively on each transfer, where a transfer is tx_valid=1 and tx_ready=1 on a clk edge.
REQ-024 While tx_valid=1 and tx_ready=0, tx_data SHALL be held stable; tx_valid SHALL never drop before a transfer.
REQ-025 tx_valid SHALL be 0 and tx_data SHALL be 8'h00 outside SEND.
REQ-026 A full transmission with tx_ready held at 1 SHALL occupy exactly NB cycles in SEND, followed by 1 cycle in DONE.
REQ-027 Saturation limit LIM SHALL be 10^BCD_DIGITS - 1.
- If the hold value > LIM, the converted value SHALL be LIM.
- If LIM is not less than 2^DATA_W - 1, no saturation SHALL occur.
- The comparison SHALL be performed at a width that cannot overflow.
REQ-028 BCD conversion SHALL be a sequential shift-and-add-3 (double dabble) conversion of the saturated value, one bit per cycle, taking DATA_W cycles.
REQ-029 The conversion SHALL start on the edge after an accepted capture.
- bcd_out SHALL update atomically, and bcd_valid SHALL rise, on the edge DATA_W+1 cycles after the capture edge.
- bcd_out SHALL hold its previous value in the meantime.
REQ-030 bcd_valid SHALL fall on the edge of an accepted capture and stay 0 until the conversion completes.
REQ-031 An accepted capture during a conversion SHALL abort it and restart the conversion with the new value; no intermediate bcd_out update SHALL occur.
REQ-032 Conversion and transmission SHALL run independently; start SHALL be permitted while bcd_valid=0.

Reset
REQ-033 On reset=1 the block SHALL return to the following values on the next edge, regardless of any operation in progress:
- FSM = IDLE, idx cleared, hold register = 0, en_disp = 0;
- conversion aborted, bcd_out = 0, bcd_valid = 0;
- tx_valid = 0, tx_data = 8'h00, busy = 0, done = 0.
REQ-034 capture and start SHALL be ignored in any cycle with reset=1.

Verification
REQ-035 Capture 32'h12345678, MSB_FIRST=0, tx_ready=1, then start -> tx_data 78,56,34,12 on consecutive cycles; done pulses 1 cycle after the last byte; busy high for 5 cycles.
REQ-036 Same stimulus with MSB_FIRST=1 and tx_ready toggling 1,0,0,1 repeatedly -> bytes 12,34,56,78; each byte is held stable while tx_ready=0; no byte is lost or duplicated.
REQ-037 Capture 32'd12345678 with disp_mode=1 -> bcd_out=32'h12345678, bcd_valid=1, exactly 33 cycles after the capture edge; en_disp=1.
REQ-038 Capture 32'hFFFFFFFF -> bcd_out=32'h99999999; a second capture of 32'd5 issued 10 cycles later -> no intermediate update; final bcd_out=32'h00000005.
REQ-039 Capture during SEND -> ignored, remaining bytes come from the old value; start and capture in the same IDLE cycle -> capture taken, no transmission.
REQ-040 Assert reset mid-SEND and mid-conversion -> next cycle all outputs are 0, FSM is IDLE, and a following start transmits byte 00 data.

Source files
------------

// File: rtl/result_serializer.sv
// result_serializer
// Holds a captured result, streams it byte-wise to a UART transmitter over a
// valid/ready handshake, and independently converts the (saturated) held value
// to packed BCD for a numeric display using a bit-serial double-dabble engine.

module result_serializer #(
  parameter int DATA_W     = 32,
  parameter int BCD_DIGITS = 8,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    capture,
  input  logic [DATA_W-1:0]       result_data,
  input  logic                    disp_mode,
  input  logic                    start,
  input  logic                    tx_ready,
  output logic                    tx_valid,
  output logic [7:0]              tx_data,
  output logic                    busy,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd_out,
  output logic                    bcd_valid,
  output logic                    en_disp
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int BW    = 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(DATA_W) + 1;
  // 65 bits holds both 2^64-1 and 10^16-1, so the saturation compare never wraps.
  localparam int CW    = 65;

  localparam logic [IDX_W-1:0] IDX_FIRST = MSB_FIRST ? IDX_W'(NB - 1) : IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_LAST  = MSB_FIRST ? IDX_W'(0) : IDX_W'(NB - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_W - 1);

  // 10^digits - 1, evaluated at elaboration time.
  function automatic logic [CW-1:0] calc_limit(input int digits);
    logic [CW-1:0] p;
    p = 65'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 65'd10;
    end
    return p - 65'd1;
  endfunction

  localparam logic [CW-1:0] LIM = calc_limit(BCD_DIGITS);

  // Clamp the held value to the largest number the display can show.
  function automatic logic [DATA_W-1:0] saturate(input logic [DATA_W-1:0] v);
    logic [CW-1:0] wide;
    wide = {{(CW - DATA_W){1'b0}}, v};
    if (wide > LIM) begin
      return LIM[DATA_W-1:0];
    end else begin
      return v;
    end
  endfunction

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
  function automatic logic [BW-1:0] dabble_step(input logic [BW-1:0] acc, input logic bit_in);
    logic [BW-1:0] adj;
    adj = acc;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (adj[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
      end else begin
        adj[4*d +: 4] = adj[4*d +: 4];
      end
    end
    return {adj[BW-2:0], bit_in};
  endfunction

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Transmit FSM and its registered outputs
  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               tx_valid_q, tx_valid_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Held result
  logic [DATA_W-1:0]  hold_q, hold_d;
  logic               en_disp_q, en_disp_d;

  // Conversion engine
  logic               load_q, load_d;
  logic               conv_act_q, conv_act_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [BW-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]      bcd_q, bcd_d;
  logic               bcd_valid_q, bcd_valid_d;

  logic               capture_ok_s;
  logic               transfer_s;
  logic [BW-1:0]      step_acc_s;
  logic [7:0]         byte_s [NB];

  // A capture is only honoured while no transmission is using the hold register.
  assign capture_ok_s = capture & ~busy_q;
  assign transfer_s   = tx_valid_q & tx_ready;
  assign step_acc_s   = dabble_step(acc_q, shift_q[DATA_W-1]);

  for (genvar g = 0; g < NB; g++) begin : g_bytes
    assign byte_s[g] = hold_q[8*g +: 8];
  end

  // Next-state and next-output logic of the transmit FSM.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        // A simultaneous capture wins; the start request is dropped.
        if (start && !capture) begin
          state_d = S_SEND;
          idx_d   = IDX_FIRST;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (transfer_s) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else if (MSB_FIRST) begin
            idx_d = idx_q - IDX_W'(1);
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = S_SEND;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are computed from the next state.
    tx_valid_d = (state_d == S_SEND);
    if (state_d == S_SEND) begin
      tx_data_d = byte_s[idx_d];
    end else begin
      tx_data_d = 8'h00;
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Transmit FSM state and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= IDX_W'(0);
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Hold register and display enable load on an accepted capture.
  always_comb begin
    hold_d    = hold_q;
    en_disp_d = en_disp_q;
    if (capture_ok_s) begin
      hold_d    = result_data;
      en_disp_d = disp_mode;
    end else begin
      hold_d    = hold_q;
      en_disp_d = en_disp_q;
    end
  end

  // Hold register and display enable storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q    <= '0;
      en_disp_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      en_disp_q <= en_disp_d;
    end
  end

  // Conversion sequencing: capture arms a load, the load edge snapshots the
  // saturated value, then DATA_W shift steps; only the last step publishes.
  always_comb begin
    load_d      = load_q;
    conv_act_d  = conv_act_q;
    shift_d     = shift_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    bcd_valid_d = bcd_valid_q;
    if (capture_ok_s) begin
      // New value: abandon any running conversion, keep the old bcd_out shown.
      load_d      = 1'b1;
      conv_act_d  = 1'b0;
      bcd_valid_d = 1'b0;
    end else if (load_q) begin
      load_d     = 1'b0;
      conv_act_d = 1'b1;
      shift_d    = saturate(hold_q);
      acc_d      = '0;
      cnt_d      = CNT_W'(0);
    end else if (conv_act_q) begin
      acc_d   = step_acc_s;
      shift_d = {shift_q[DATA_W-2:0], 1'b0};
      cnt_d   = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LAST) begin
        conv_act_d  = 1'b0;
        bcd_d       = step_acc_s;
        bcd_valid_d = 1'b1;
      end else begin
        conv_act_d  = 1'b1;
      end
    end else begin
      conv_act_d = 1'b0;
    end
  end

  // Conversion engine registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_q      <= 1'b0;
      conv_act_q  <= 1'b0;
      shift_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= CNT_W'(0);
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
    end else begin
      load_q      <= load_d;
      conv_act_q  <= conv_act_d;
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
    end
  end

  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign bcd_out   = bcd_q;
  assign bcd_valid = bcd_valid_q;
  assign en_disp   = en_disp_q;

endmodule

// File: tb/tb_result_serializer.sv
// Scoreboard bench for result_serializer: two instances (LSB-first with
// tx_ready tied high, MSB-first with tx_ready toggling 1,0,0,1) share the
// capture/start stimulus; monitors pop expected bytes and BCD results.

module tb_result_serializer;

  logic        clk = 1'b0;
  logic        reset, capture, disp_mode, start;
  logic        tx_ready0, tx_ready1;
  logic [31:0] result_data;

  logic        tx_valid0, busy0, done0, bcd_valid0, en_disp0;
  logic [7:0]  tx_data0;
  logic [31:0] bcd_out0;
  logic        tx_valid1, busy1, done1, bcd_valid1, en_disp1;
  logic [7:0]  tx_data1;
  logic [31:0] bcd_out1;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;
  logic rst_seen = 1'b1;
  bit   armed = 1'b0;

  logic [7:0]  exp_tx0 [$];
  logic [7:0]  exp_tx1 [$];
  logic [31:0] exp_bcd [$];
  int          exp_due [$];
  logic [31:0] model_hold = 32'h0;

  always #5 clk = ~clk;

  result_serializer #(.DATA_W(32), .BCD_DIGITS(8), .MSB_FIRST(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .capture(capture), .result_data(result_data),
    .disp_mode(disp_mode), .start(start), .tx_ready(tx_ready0),
    .tx_valid(tx_valid0), .tx_data(tx_data0), .busy(busy0), .done(done0),
    .bcd_out(bcd_out0), .bcd_valid(bcd_valid0), .en_disp(en_disp0)
  );

  result_serializer #(.DATA_W(32), .BCD_DIGITS(8), .MSB_FIRST(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .capture(capture), .result_data(result_data),
    .disp_mode(disp_mode), .start(start), .tx_ready(tx_ready1),
    .tx_valid(tx_valid1), .tx_data(tx_data1), .busy(busy1), .done(done1),
    .bcd_out(bcd_out1), .bcd_valid(bcd_valid1), .en_disp(en_disp1)
  );

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    rst_seen <= reset;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic spurious(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected no event", name, act);
  endtask

  // tx_ready pattern for the MSB-first instance
  initial begin
    logic [3:0] pat;
    pat = 4'b1001;
    tx_ready1 = 1'b1;
    forever begin
      for (int k = 0; k < 4; k++) begin
        @(posedge clk);
        #1;
        tx_ready1 = pat[3-k];
      end
    end
  end

  // Byte monitor, LSB-first instance
  logic       pv0 = 1'b0, pr0 = 1'b0;
  logic [7:0] pd0 = 8'h00;
  always @(negedge clk) begin
    if (armed) begin
      if (pv0 && !pr0 && !rst_seen) begin
        check("tx0_valid_held", 64'(tx_valid0), 64'd1);
        check("tx0_data_held", 64'(tx_data0), 64'(pd0));
      end
      if (tx_valid0 && tx_ready0) begin
        if (exp_tx0.size() == 0) spurious("tx0_unexpected_byte", 64'(tx_data0));
        else check("tx0_byte", 64'(tx_data0), 64'(exp_tx0.pop_front()));
      end
    end
    pv0 <= tx_valid0; pr0 <= tx_ready0; pd0 <= tx_data0;
  end

  // Byte monitor, MSB-first instance
  logic       pv1 = 1'b0, pr1 = 1'b0;
  logic [7:0] pd1 = 8'h00;
  always @(negedge clk) begin
    if (armed) begin
      if (pv1 && !pr1 && !rst_seen) begin
        check("tx1_valid_held", 64'(tx_valid1), 64'd1);
        check("tx1_data_held", 64'(tx_data1), 64'(pd1));
      end
      if (tx_valid1 && tx_ready1) begin
        if (exp_tx1.size() == 0) spurious("tx1_unexpected_byte", 64'(tx_data1));
        else check("tx1_byte", 64'(tx_data1), 64'(exp_tx1.pop_front()));
      end
    end
    pv1 <= tx_valid1; pr1 <= tx_ready1; pd1 <= tx_data1;
  end

  // BCD monitor: value and completion edge on bcd_valid rise, no other updates
  logic        pbv = 1'b0;
  logic [31:0] pbcd = 32'h0;
  always @(negedge clk) begin
    if (armed && !rst_seen) begin
      if (bcd_valid0 && !pbv) begin
        if (exp_bcd.size() == 0) spurious("bcd_unexpected_result", 64'(bcd_out0));
        else begin
          check("bcd_value", 64'(bcd_out0), 64'(exp_bcd.pop_front()));
          check("bcd_latency_edge", 64'(edge_cnt), 64'(exp_due.pop_front()));
        end
      end else if (bcd_out0 !== pbcd) begin
        spurious("bcd_intermediate_update", 64'(bcd_out0));
      end
    end
    pbv <= bcd_valid0; pbcd <= bcd_out0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_capture(input logic [31:0] v, input logic dm, input logic with_start,
                            input logic accepted, input logic [31:0] bcd_exp);
    result_data = v; disp_mode = dm; capture = 1'b1; start = with_start;
    tick();
    capture = 1'b0; start = 1'b0;
    if (accepted) begin
      model_hold = v;
      exp_bcd.delete(); exp_due.delete();
      exp_bcd.push_back(bcd_exp);
      exp_due.push_back(edge_cnt + 33);
      check("bcd_valid_fall", 64'(bcd_valid0), 64'd0);
    end
  endtask

  task automatic do_start();
    for (int i = 0; i < 4; i++) begin
      exp_tx0.push_back(model_hold[8*i +: 8]);
      exp_tx1.push_back(model_hold[8*(3-i) +: 8]);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!busy0 && !busy1) break;
      tick();
    end
    check("idle_within_budget", 64'(busy0 | busy1), 64'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_tx_valid0"}, 64'(tx_valid0), 64'd0);
    check({tag, "_tx_data0"}, 64'(tx_data0), 64'd0);
    check({tag, "_busy0"}, 64'(busy0), 64'd0);
    check({tag, "_done0"}, 64'(done0), 64'd0);
    check({tag, "_bcd_out0"}, 64'(bcd_out0), 64'd0);
    check({tag, "_bcd_valid0"}, 64'(bcd_valid0), 64'd0);
    check({tag, "_en_disp0"}, 64'(en_disp0), 64'd0);
    check({tag, "_tx_valid1"}, 64'(tx_valid1), 64'd0);
    check({tag, "_busy1"}, 64'(busy1), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bc, dc, di;
    reset = 1'b1; capture = 1'b0; start = 1'b0; disp_mode = 1'b0;
    result_data = 32'h0; tx_ready0 = 1'b1;
    // Capture and start must be ignored while reset is high.
    tick();
    capture = 1'b1; start = 1'b1; result_data = 32'hDEADBEEF;
    tick();
    capture = 1'b0; start = 1'b0;
    check_zero_outputs("reset");
    reset = 1'b0;
    tick();
    armed = 1'b1;
    check("no_start_under_reset", 64'(busy0), 64'd0);

    // Decimal value converts without saturation, 33 edges after capture.
    do_capture(32'd12345678, 1'b1, 1'b0, 1'b1, 32'h12345678);
    repeat (34) tick();
    check("bcd_valid_after_conv", 64'(bcd_valid0), 64'd1);
    check("bcd_out_12345678", 64'(bcd_out0), 64'h12345678);
    check("en_disp_loaded", 64'(en_disp0), 64'd1);

    // Saturating value; transmission started while conversion is running.
    do_capture(32'h12345678, 1'b1, 1'b0, 1'b1, 32'h99999999);
    do_start();
    bc = 0; dc = 0; di = -1;
    for (int i = 0; i < 8; i++) begin
      bc += int'(busy0);
      if (done0) begin dc++; di = i; end
      tick();
    end
    check("busy_cycles", 64'(bc), 64'd5);
    check("done_pulses", 64'(dc), 64'd1);
    check("done_position", 64'(di), 64'd4);
    wait_idle();
    repeat (36) tick();
    check("tx0_queue_drained", 64'(exp_tx0.size()), 64'd0);
    check("tx1_queue_drained", 64'(exp_tx1.size()), 64'd0);
    check("bcd_saturated", 64'(bcd_out0), 64'h99999999);

    // Capture during SEND is ignored entirely.
    do_start();
    tick();
    do_capture(32'hAABBCCDD, 1'b0, 1'b0, 1'b0, 32'h0);
    check("bcd_valid_kept_busy_capture", 64'(bcd_valid0), 64'd1);
    wait_idle();
    repeat (4) tick();
    check("en_disp_kept_busy_capture", 64'(en_disp0), 64'd1);
    check("tx0_old_bytes_drained", 64'(exp_tx0.size()), 64'd0);
    check("tx1_old_bytes_drained", 64'(exp_tx1.size()), 64'd0);

    // Start and capture together: capture wins, nothing is sent.
    do_capture(32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 32'h99999999);
    repeat (3) tick();
    check("start_dropped_busy0", 64'(busy0), 64'd0);
    check("start_dropped_busy1", 64'(busy1), 64'd0);
    check("en_disp_cleared", 64'(en_disp0), 64'd0);
    repeat (6) tick();
    // Restart 10 cycles after the previous capture edge.
    do_capture(32'd5, 1'b0, 1'b0, 1'b1, 32'h00000005);
    repeat (36) tick();
    check("bcd_restart_final", 64'(bcd_out0), 64'h5);
    check("bcd_restart_valid", 64'(bcd_valid0), 64'd1);
    check("bcd_queue_drained", 64'(exp_bcd.size()), 64'd0);

    // Reset in the middle of a transmission and a conversion.
    do_capture(32'hCAFEF00D, 1'b1, 1'b0, 1'b1, 32'h99999999);
    do_start();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_tx0.delete(); exp_tx1.delete(); exp_bcd.delete(); exp_due.delete();
    model_hold = 32'h0;
    check_zero_outputs("midrun_reset");
    tick();
    do_start();
    wait_idle();
    repeat (3) tick();
    check("post_reset_tx0_drained", 64'(exp_tx0.size()), 64'd0);
    check("post_reset_tx1_drained", 64'(exp_tx1.size()), 64'd0);
    check("post_reset_bcd_valid", 64'(bcd_valid0), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
